life_controller: RTL and testbench

Game-state owner for the player's remaining lives: it counts lives, runs the respawn delay after a lost ball and declares game over. It sits directly upstream of indications_block and drives its `life` input. Its respawn/game-over outputs also gate the ball and flipper logic. It is frame-paced by the VGA start-of-frame tick and has no pixel-domain logic.

---
 rtl/life_controller_pkg.sv | 15 +
 rtl/life_controller_frame_delay.sv | 31 +++
 rtl/life_controller.sv | 118 +++++++++++
 tb/tb_life_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/life_controller_pkg.sv
// Shared constants and state type for the life/respawn game-state logic.
package defines;

  localparam int LIFE_INIT      = 3;
  localparam int LIFE_MAX       = 9;
  localparam int RESPAWN_FRAMES = 60;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RESPAWN,
    GAME_OVER
  } life_state_t;

endpackage

// File: rtl/life_controller_frame_delay.sv
// frame_delay_counter: counts start-of-frame ticks while not cleared and
// flags the tick that completes RESPAWN_FRAMES frames.
module frame_delay_counter #(
  parameter int RESPAWN_FRAMES = defines::RESPAWN_FRAMES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic startOfFrame,
  output logic done
);

  localparam int CW = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(RESPAWN_FRAMES - 1);

  logic [CW-1:0] count_q;

  // Combinational so the owner can react in the same cycle as the final tick.
  assign done = !clear && startOfFrame && (count_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (startOfFrame) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/life_controller.sv
// life_controller: owns the life count, respawn delay and game-over state.
// Optional extra-life support is enabled by defining LIFE_CTRL_EXTRA_LIFE_EN.
module life_controller
  import defines::*;
#(
  parameter int LIFE_INIT      = defines::LIFE_INIT,
  parameter int LIFE_MAX       = defines::LIFE_MAX,
  parameter int RESPAWN_FRAMES = defines::RESPAWN_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       newGame,
  input  logic       ballLost,
  input  logic       extraLife,
  output logic [3:0] life,
  output logic       respawnActive,
  output logic       ballRespawn,
  output logic       gameOver
);

  localparam logic [3:0] INIT4 = 4'(LIFE_INIT);

  life_state_t state_q, state_d;
  logic [3:0]  life_q, life_d;
  logic        respawn_pulse_d;
  logic        respawn_active_q, ball_respawn_q, game_over_q;
  logic        frames_done;
  logic        gain;
  logic [3:0]  life_inc;

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  localparam logic [3:0] MAX4 = 4'(LIFE_MAX);
  assign gain     = extraLife;
  assign life_inc = (life_q >= MAX4) ? MAX4 : life_q + 4'd1;
`else
  logic unused_extra_life;
  assign unused_extra_life = extraLife;
  assign gain              = 1'b0;
  assign life_inc          = life_q;
`endif

  frame_delay_counter #(
    .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) u_respawn_delay (
    .clk         (clk),
    .reset       (reset),
    .clear       ((state_q != RESPAWN) || newGame),
    .startOfFrame(startOfFrame),
    .done        (frames_done)
  );

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d         = state_q;
    life_d          = life_q;
    respawn_pulse_d = 1'b0;
    if (newGame) begin
      state_d         = PLAY;
      life_d          = INIT4;
      respawn_pulse_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (ballLost) begin
            if (gain) begin
              // Decrement applies to the saturated increment: MAX stays MAX-1.
              life_d  = life_inc - 4'd1;
              state_d = RESPAWN;
            end else if (life_q >= 4'd2) begin
              life_d  = life_q - 4'd1;
              state_d = RESPAWN;
            end else begin
              life_d  = '0;
              state_d = GAME_OVER;
            end
          end else if (gain) begin
            life_d = life_inc;
          end
        end
        RESPAWN: begin
          if (gain) life_d = life_inc;
          if (frames_done) begin
            state_d         = PLAY;
            respawn_pulse_d = 1'b1;
          end
        end
        GAME_OVER: life_d = '0;
        default:   state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset returns every output register to its idle value immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      life_q           <= INIT4;
      respawn_active_q <= 1'b0;
      ball_respawn_q   <= 1'b0;
      game_over_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      life_q           <= life_d;
      respawn_active_q <= (state_d == RESPAWN);
      ball_respawn_q   <= respawn_pulse_d;
      game_over_q      <= (state_d == GAME_OVER);
    end
  end

  assign life          = life_q;
  assign respawnActive = respawn_active_q;
  assign ballRespawn   = ball_respawn_q;
  assign gameOver      = game_over_q;

endmodule

// File: tb/tb_life_controller.sv
// Self-checking bench for life_controller: directed scenarios with literal
// expectations, then random stimulus compared every cycle to a lives model.
module tb_life_controller;

  localparam int L_INIT = 3;
  localparam int L_MAX  = 9;
  localparam int FRAMES = 60;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  localparam bit EXTRA_EN = 1'b1;
`else
  localparam bit EXTRA_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0, newGame = 1'b0, ballLost = 1'b0, extraLife = 1'b0;
  logic [3:0] life;
  logic       respawnActive, ballRespawn, gameOver;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  life_controller #(
    .LIFE_INIT(L_INIT), .LIFE_MAX(L_MAX), .RESPAWN_FRAMES(FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .newGame(newGame),
    .ballLost(ballLost), .extraLife(extraLife), .life(life),
    .respawnActive(respawnActive), .ballRespawn(ballRespawn), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: lives as a plain integer, game phase as a word,
  // and the number of frames already waited out in the respawn phase.
  string m_phase = "idle";
  int    m_lives = L_INIT;
  int    m_waited = 0;
  bit    m_pulse = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = "idle"; m_lives = L_INIT; m_waited = 0; m_pulse = 1'b0;
    end else begin
      bit bonus;
      bonus   = EXTRA_EN && extraLife;
      m_pulse = 1'b0;
      if (newGame) begin
        m_phase = "play"; m_lives = L_INIT; m_waited = 0; m_pulse = 1'b1;
      end else if (m_phase == "play") begin
        if (ballLost && bonus) begin
          m_lives = ((m_lives + 1 > L_MAX) ? L_MAX : m_lives + 1) - 1;
          m_phase = "respawn"; m_waited = 0;
        end else if (ballLost) begin
          m_lives = m_lives - 1;
          if (m_lives <= 0) begin m_lives = 0; m_phase = "over"; end
          else begin m_phase = "respawn"; m_waited = 0; end
        end else if (bonus) begin
          m_lives = (m_lives + 1 > L_MAX) ? L_MAX : m_lives + 1;
        end
      end else if (m_phase == "respawn") begin
        if (bonus) m_lives = (m_lives + 1 > L_MAX) ? L_MAX : m_lives + 1;
        if (startOfFrame) begin
          m_waited++;
          if (m_waited == FRAMES) begin m_phase = "play"; m_pulse = 1'b1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_life", life, m_lives);
      check("model_respawnActive", respawnActive, m_phase == "respawn");
      check("model_gameOver", gameOver, m_phase == "over");
      check("model_ballRespawn", ballRespawn, m_pulse);
    end
  end

  task automatic tick(input bit sof, input bit ng, input bit bl, input bit el);
    startOfFrame = sof; newGame = ng; ballLost = bl; extraLife = el;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0; newGame = 1'b0; ballLost = 1'b0; extraLife = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check("reset_life", life, 3);
    check("reset_gameOver", gameOver, 0);
    check("reset_respawnActive", respawnActive, 0);
    check("reset_ballRespawn", ballRespawn, 0);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("newgame_life", life, 3);
    check("newgame_pulse", ballRespawn, 1);
    check("newgame_gameOver", gameOver, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("newgame_pulse_once", ballRespawn, 0);

    // A frame tick in the same cycle as the loss must not be counted.
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check("loss1_life", life, 2);
    check("loss1_respawnActive", respawnActive, 1);
    frames(FRAMES - 1);
    check("respawn_wait_active", respawnActive, 1);
    check("respawn_wait_nopulse", ballRespawn, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("respawn_done_pulse", ballRespawn, 1);
    check("respawn_done_inactive", respawnActive, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("respawn_pulse_once", ballRespawn, 0);
    check("loss2_life", life, 1);
    frames(FRAMES);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("loss3_life", life, 0);
    check("loss3_gameOver", gameOver, 1);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    check("over_hold_life", life, 0);
    check("over_hold_gameOver", gameOver, 1);

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("extra_saturate", life, 9);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("extra_loss_at_max", life, 8);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    frames(FRAMES);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("extra_loss_net_life", life, 2);
    check("extra_loss_net_respawn", respawnActive, 1);
`else
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("extra_ignored", life, 3);
`endif

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    frames(30);
    #1 reset = 1'b1;
    #1;
    check("midreset_life", life, 3);
    check("midreset_respawnActive", respawnActive, 0);
    check("midreset_gameOver", gameOver, 0);
    check("midreset_ballRespawn", ballRespawn, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    check("idle_ignores_life", life, 3);
    check("idle_ignores_respawn", respawnActive, 0);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    frames(10);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("ng_in_respawn_life", life, 3);
    check("ng_in_respawn_active", respawnActive, 0);
    check("ng_in_respawn_pulse", ballRespawn, 1);

    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 1) == 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b1;
        #5 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
